// File: rtl/sc_out_port_bcd_display_if.sv
// CPU output-port to BCD display bundle: the CPU drives port_value, the display
// returns its active-low segment vector and conversion status.
interface sc_out_port_bcd_display_if #(
  parameter int unsigned DIGITS = 5
);
  logic [31:0]         port_value;
  logic [7*DIGITS-1:0] hex_out;
  logic                busy;
  logic                update;

  modport master (output port_value, input hex_out, input busy, input update);
  modport slave  (input port_value, output hex_out, output busy, output update);
endinterface

// File: rtl/sc_out_port_bcd_display.sv
// Sequential double-dabble converter of the CPU output port onto active-low
// seven-segment digits; the display only changes when a conversion completes.
module sc_out_port_bcd_display #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIGITS     = 5,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic                       clock,
  input  logic                       resetn,
  sc_out_port_bcd_display_if.slave   bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned HEX_W = 7 * DIGITS;
  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_last_value;
  logic [DATA_WIDTH-1:0] r_shift_bin;
  logic [BCD_W-1:0]      r_bcd_work;
  logic [CNT_W-1:0]      r_cnt;
  logic [HEX_W-1:0]      r_hex_disp;
  logic                  r_busy;
  logic                  r_update;

  logic [DATA_WIDTH-1:0] w_port;
  logic [BCD_W-1:0]      w_bcd_adj;
  logic                  w_start;
  logic                  w_last_step;
  logic                  w_unused_port_hi;

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-BCD codes go dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h7F;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Full display vector, scanning from the most significant digit so leading
  // zeros can be blanked; digit 0 is always lit.
  function automatic logic [HEX_W-1:0] hex_of(input logic [BCD_W-1:0] bcd);
    logic [HEX_W-1:0] h;
    logic [3:0]       d;
    logic             lead;
    h    = '0;
    lead = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      d = bcd[4*i +: 4];
      if (d != 4'd0) lead = 1'b0;
      if (BLANK_LZ && lead && (i != 0)) h[7*i +: 7] = 7'h7F;
      else                              h[7*i +: 7] = seg7(d);
    end
    return h;
  endfunction

  // Add-3 correction applied to every BCD nibble before each shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] b;
    b = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (b[4*i +: 4] >= 4'd5) b[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return b;
  endfunction

  assign w_port           = bus.port_value[DATA_WIDTH-1:0];
  assign w_unused_port_hi = ^bus.port_value[31:DATA_WIDTH];
  assign w_start          = (r_state == S_IDLE) && (w_port != r_last_value);
  assign w_last_step      = (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_bcd_adj        = add3(r_bcd_work);

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)     w_state_nxt = S_CONV;
      S_CONV:  if (w_last_step) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Conversion datapath; the display register is only loaded in DONE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_last_value <= '0;
      r_shift_bin  <= '0;
      r_bcd_work   <= '0;
      r_cnt        <= '0;
      r_hex_disp   <= hex_of(BCD_W'(0));
      r_busy       <= 1'b0;
      r_update     <= 1'b0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_last_value <= w_port;
            r_shift_bin  <= w_port;
            r_bcd_work   <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
          end
        end
        S_CONV: begin
          r_bcd_work  <= {w_bcd_adj[BCD_W-2:0], r_shift_bin[DATA_WIDTH-1]};
          r_shift_bin <= {r_shift_bin[DATA_WIDTH-2:0], 1'b0};
          r_cnt       <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          r_hex_disp <= hex_of(r_bcd_work);
          r_update   <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.hex_out = r_hex_disp;
  assign bus.busy    = r_busy;
  assign bus.update  = r_update;

endmodule

// File: tb/tb_sc_out_port_bcd_display.sv
// Directed bench for sc_out_port_bcd_display: scoreboard of expected displays
// popped on each update pulse, plus timing and blanking checks.
module tb_sc_out_port_bcd_display;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sc_out_port_bcd_display_if #(.DIGITS(5)) b1 ();
  sc_out_port_bcd_display_if #(.DIGITS(5)) b2 ();

  sc_out_port_bcd_display #(.DATA_WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b1)) dut (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (b1.slave)
  );

  sc_out_port_bcd_display #(.DATA_WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b0)) dut_nb (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (b2.slave)
  );

  localparam logic [34:0] H_RST   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [34:0] H2_RST  = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [34:0] H_1234  = {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [34:0] H_65535 = {7'h02, 7'h12, 7'h12, 7'h30, 7'h12};
  localparam logic [34:0] H_7     = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78};
  localparam logic [34:0] H_100   = {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40};
  localparam logic [34:0] H_200   = {7'h7F, 7'h7F, 7'h24, 7'h40, 7'h40};
  localparam logic [34:0] H_42    = {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24};
  localparam logic [34:0] H2_5    = {7'h40, 7'h40, 7'h40, 7'h40, 7'h12};

  int n_checks = 0;
  int n_errors = 0;
  int upd1 = 0, upd2 = 0, busy1_cyc = 0, busy2_cyc = 0;
  logic [34:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every update pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (b1.update === 1'b1) begin
        upd1++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $error("FAIL sb_unexpected_update: observed %0h expected none", b1.hex_out);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          assert (b1.hex_out === e) else begin
            n_errors++;
            $error("FAIL sb_display: observed %0h expected %0h", b1.hex_out, e);
          end
        end
      end
      if (b1.busy === 1'b1) busy1_cyc++;
      if (b2.update === 1'b1) upd2++;
      if (b2.busy === 1'b1) busy2_cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, u0, b0;
    rst_n = 1'b0;
    b1.port_value = 32'h0;
    b2.port_value = 32'h0;
    #12;
    chk("rst_hex", 64'(b1.hex_out), 64'(H_RST));
    chk("rst_busy", 64'(b1.busy), 64'd0);
    chk("rst_update", 64'(b1.update), 64'd0);
    chk("rst_hex_noblank", 64'(b2.hex_out), 64'(H2_RST));

    // Zero held: nothing converts on the blanking instance; 5 on the other.
    @(negedge clk);
    rst_n = 1'b1;
    b2.port_value = 32'd5;
    cycles(30);
    chk("zero_busy_cycles", 64'(busy1_cyc), 64'd0);
    chk("zero_updates", 64'(upd1), 64'd0);
    chk("zero_hex", 64'(b1.hex_out), 64'(H_RST));
    chk("nb5_hex", 64'(b2.hex_out), 64'(H2_5));
    chk("nb5_updates", 64'(upd2), 64'd1);

    // 1234: latency, busy width and single update.
    u0 = upd1;
    b1.port_value = 32'd1234;
    b2.port_value = 32'hFFFF_0005;
    exp_q.push_back(H_1234);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (b1.update !== 1'b1 && lat < 40);
    chk("latency_1234", 64'(lat), 64'd18);
    cycles(10);
    chk("busy_cycles_1234", 64'(busy1_cyc), 64'd17);
    chk("updates_1234", 64'(upd1 - u0), 64'd1);
    chk("nb_upper_bits_hex", 64'(b2.hex_out), 64'(H2_5));
    chk("nb_upper_bits_updates", 64'(upd2), 64'd1);
    chk("nb_upper_bits_busy", 64'(busy2_cyc), 64'd17);

    // Maximum value then a small one.
    b1.port_value = 32'd65535;
    exp_q.push_back(H_65535);
    cycles(30);
    chk("hex_65535", 64'(b1.hex_out), 64'(H_65535));
    b1.port_value = 32'd7;
    exp_q.push_back(H_7);
    cycles(30);
    chk("hex_7", 64'(b1.hex_out), 64'(H_7));

    // Port change mid-conversion: 100 shown, then 200.
    u0 = upd1;
    b0 = busy1_cyc;
    b1.port_value = 32'd100;
    exp_q.push_back(H_100);
    exp_q.push_back(H_200);
    cycles(5);
    b1.port_value = 32'd200;
    cycles(50);
    chk("midconv_updates", 64'(upd1 - u0), 64'd2);
    chk("midconv_busy_cycles", 64'(busy1_cyc - b0), 64'd34);
    chk("midconv_hex", 64'(b1.hex_out), 64'(H_200));

    // Asynchronous reset in the middle of a conversion.
    b1.port_value = 32'd999;
    cycles(5);
    chk("pre_reset_busy", 64'(b1.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hex", 64'(b1.hex_out), 64'(H_RST));
    chk("async_rst_busy", 64'(b1.busy), 64'd0);
    chk("async_rst_update", 64'(b1.update), 64'd0);
    chk("async_rst_hex_noblank", 64'(b2.hex_out), 64'(H2_RST));
    b1.port_value = 32'd42;
    exp_q.push_back(H_42);
    cycles(2);
    rst_n = 1'b1;
    cycles(30);
    chk("hex_42", 64'(b1.hex_out), 64'(H_42));
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sc_out_port_bcd_display.md
Name: sc_out_port_bcd_display

Overview:
- Downstream consumer of `out_port0` of the single-cycle computer; turns the low `DATA_WIDTH` bits of the port into decimal on active-low seven-segment digits.
- Converts sequentially with a shift-add-3 (double-dabble) state machine, one bit per clock.
- Starts a conversion only when the port value changes.
- Holds the last completed result on the display while busy, so the CPU can update the port at any rate.

Parameters:
- DATA_WIDTH, 16, number of low port bits converted (legal: 8 or 16).
- DIGITS, 5, number of decimal digits driven (must be 3 for DATA_WIDTH=8, 5 for 16).
- BLANK_LZ, 1, 1 = blank leading zeros (digit 0 always lit); 0 = show all zeros.

Ports:
- clock  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- port_value  input  32  CPU output port; bits [31:DATA_WIDTH] ignored.
- hex_out  output  7*DIGITS  segments, digit i at [7i+6:7i], order {g,f,e,d,c,b,a}, active low.
- busy  output  1  high while a conversion is in progress.
- update  output  1  one-cycle pulse on the edge `hex_out` takes a new value.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; `last_value`=0; `bcd_disp`=0; `busy`=0; `update`=0.
  - `hex_out`: digit0=7'h40 ("0"); other digits 7'h7F (blank) if BLANK_LZ=1, else 7'h40.
- IDLE:
  - If `port_value[DATA_WIDTH-1:0] != last_value` at a rising edge: capture it into `shift_bin` and `last_value`, clear `bcd_work`, set `cnt`=0, go to CONV, `busy`=1.
  - Otherwise stay in IDLE.
- CONV, each edge:
  - Every 4-bit nibble of `bcd_work` that is >=5 gets +3.
  - Then {`bcd_work`,`shift_bin`} shifts left 1.
  - `cnt` increments.
  - When `cnt`==DATA_WIDTH-1 at the edge, go to DONE.
  - Exactly DATA_WIDTH shift steps are performed.
- DONE, one edge: `bcd_disp` <= `bcd_work`; `update`=1 for this cycle only; `busy`=0; go to IDLE.
- Latency: capture edge E, display changes at edge E+DATA_WIDTH+1 (17 edges for 16 bits).
- Port changes during CONV/DONE are ignored for the running conversion. The next IDLE cycle compares against `last_value` and restarts if they differ, so the final stable value is always displayed.
- Back-to-back conversions: minimum spacing is DATA_WIDTH+2 cycles (IDLE compare cycle included).
- Segment decode is combinational from registered `bcd_disp`:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
  - Any nibble >9 (cannot occur) decodes to 7'h7F.
- Leading-zero blanking, BLANK_LZ=1: digit i (i>0) is blank when it and all higher digits are 0.
- Max value (2^DATA_WIDTH-1) always fits DIGITS digits; no overflow path.
- Reset mid-conversion aborts immediately and returns to the reset display. After reset, the first edge with a nonzero port starts a new conversion.
- The conversion path never writes `hex_out` directly, so no glitching intermediate values appear on the display.

Test Plan:
- Reset, then `port_value`=32'h0 held -> `hex_out`={7F,7F,7F,7F,40}; `busy` never rises; `update` stays 0.
- `port_value`=1234 -> `busy` high for 17 cycles; `update` pulses once; digits {blank,1,2,3,4} = {7F,79,24,30,19}.
- `port_value`=65535 -> digits {6,5,5,3,5} = {02,12,12,30,12}. Then `port_value`=7 -> {7F,7F,7F,7F,78}.
- Port changes 100 -> 200 at cycle 5 of a conversion -> "100" displayed first with one `update`. A second conversion follows immediately; "200" displayed. Exactly two `update` pulses.
- `resetn` asserted asynchronously mid-CONV -> outputs return to reset values without waiting for a clock edge. After release, port=42 converts normally to {7F,7F,7F,19,24}.
- BLANK_LZ=0, port=5 -> {40,40,40,40,12}. Upper port bits 32'hFFFF0005 give the same result and no extra conversion.
